// File: rtl/spi_reg_pkg.sv
// Shared constants, state encoding and helpers for the SPI register bank.
package spi_reg_pkg;

  localparam int         FRAME_BITS     = 16;
  localparam logic [4:0] CNT_FULL       = 5'd16;
  localparam logic [4:0] CNT_SAT        = 5'd17;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Saturating bit counter so over-long frames stay distinguishable from 16.
  function automatic logic [4:0] cnt_next(input logic [4:0] cnt);
    cnt_next = (cnt >= CNT_SAT) ? CNT_SAT : (cnt + 5'd1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one async pin, with a history flop for edge pulses.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Synchroniser chain plus one history stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI mode-0 slave decoding 16-bit frames into five 8-bit control registers.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_copi_level, w_copi_rise, w_copi_fall;
  logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
  logic w_unused;
  logic [6:0] w_addr;

  state_t               r_state;
  logic [15:0]          r_shift;
  logic [4:0]           r_cnt;
  logic [SYNC_STAGES:0] r_settle;
  logic                 r_armed;
  logic [7:0]           r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;
  logic                 r_wr_strobe, r_frame_err;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_async(sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .i_async(copi),
    .o_level(w_copi_level), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_async(ncs),
    .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  assign w_unused = &{1'b0, w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall};
  assign w_addr   = r_shift[14:8];

  // The reset value of the ncs chain can fake a falling edge while the real pin
  // level flushes through; arm only once a genuine high level has been observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      if (r_settle[SYNC_STAGES] && w_ncs_level) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Frame FSM, shift register, register file and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= 16'h0000;
      r_cnt       <= 5'd0;
      r_out_lo    <= 8'h00;
      r_out_hi    <= 8'h00;
      r_pwm_lo    <= 8'h00;
      r_pwm_hi    <= 8'h00;
      r_duty      <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ncs_fall && r_armed) begin
            r_state <= SHIFT;
            r_shift <= 16'h0000;
            r_cnt   <= 5'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            r_state <= COMMIT;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[14:0], w_copi_level};
            r_cnt   <= cnt_next(r_cnt);
          end else begin
            r_state <= SHIFT;
          end
        end
        COMMIT: begin
          if (r_cnt != CNT_FULL) begin
            r_frame_err <= 1'b1;
          end else if (r_shift[15] && (w_addr <= MAX_ADDR)) begin
            r_wr_strobe <= 1'b1;
            case (w_addr)
              ADDR_EN_OUT_LO: r_out_lo <= r_shift[7:0];
              ADDR_EN_OUT_HI: r_out_hi <= r_shift[7:0];
              ADDR_EN_PWM_LO: r_pwm_lo <= r_shift[7:0];
              ADDR_EN_PWM_HI: r_pwm_hi <= r_shift[7:0];
              ADDR_DUTY:      r_duty   <= r_shift[7:0];
              default:        r_duty   <= r_duty;
            endcase
          end else begin
            r_wr_strobe <= 1'b0;
          end
          if (w_ncs_fall && r_armed) begin
            r_state <= SHIFT;
            r_shift <= 16'h0000;
            r_cnt   <= 5'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign wr_strobe       = r_wr_strobe;
  assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: bit-banged SPI frames vs an array-based register model.
module tb_spi_reg_bank;

  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + 2;
  localparam int HALF        = 4;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic wr_strobe, frame_err;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  typedef struct {
    int          kind;
    logic [39:0] img;
    longint      due;
  } exp_t;

  exp_t q[$];
  logic [7:0] mem [5];

  spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] model_img();
    return {mem[4], mem[3], mem[2], mem[1], mem[0]};
  endfunction

  function automatic logic [39:0] dut_img();
    return {duty, pwm_hi, pwm_lo, out_hi, out_lo};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++) mem[i] = 8'h00;
    q.delete();
  endtask

  // Monitor: every status pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (wr_strobe || frame_err)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {62'd0, wr_strobe, frame_err}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("event_kind", {62'd0, frame_err, wr_strobe}, 64'(e.kind));
        check("event_image", 64'(dut_img()), 64'(e.img));
        check("event_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic send_bits(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = v[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  // Reference rules: only exact 16-bit frames count; write bit plus legal address commits.
  task automatic predict_and_release(input logic [31:0] v, input int nbits);
    exp_t e;
    int   addr;
    e.kind = 0;
    if (nbits != 16) begin
      e.kind = 2;
    end else begin
      addr = int'(v[14:8]);
      if (v[15] && addr <= 4) begin
        mem[addr] = v[7:0];
        e.kind = 1;
      end
    end
    ncs = 1'b1;
    e.img = model_img();
    e.due = cyc + LATENCY;
    if (e.kind != 0) q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    tick(LATENCY + 4);
    check("drain", 64'(q.size()), 64'd0);
    q.delete();
    check("idle_image", 64'(dut_img()), 64'(model_img()));
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits);
    tick(6);
    ncs = 1'b0;
    tick(HALF);
    send_bits(v, nbits);
    tick(HALF);
    predict_and_release(v, nbits);
    wait_drain();
  endtask

  initial begin
    logic [31:0] v;
    int nb;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    clear_model();
    tick(4);
    check("reset_image", 64'(dut_img()), 64'd0);
    check("reset_pulses", {62'd0, wr_strobe, frame_err}, 64'd0);
    rst = 1'b0;
    tick(4);

    send_frame(32'h80F0, 16);
    check("out_lo_f0", 64'(out_lo), 64'h0F0);
    send_frame(32'h8480, 16);
    send_frame(32'h83AA, 16);
    check("duty_80", 64'(duty), 64'h080);
    check("pwm_hi_aa", 64'(pwm_hi), 64'h0AA);
    send_frame(32'h0155, 16);
    send_frame(32'h8577, 16);
    send_frame(32'h80FF >> 1, 15);
    send_frame(32'h80FF << 1, 17);
    check("out_lo_kept", 64'(out_lo), 64'h0F0);

    // Reset in the middle of a frame.
    tick(6);
    ncs = 1'b0;
    tick(HALF);
    send_bits(32'h82, 8);
    rst = 1'b1;
    tick(2);
    ncs = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_model();
    tick(2);
    check("midframe_reset_image", 64'(dut_img()), 64'd0);
    send_frame(32'h8233, 16);
    check("pwm_lo_33", 64'(pwm_lo), 64'h033);

    // nCS held low across reset release must not start a frame.
    rst = 1'b1;
    ncs = 1'b0;
    tick(3);
    rst = 1'b0;
    clear_model();
    tick(6);
    send_bits(32'h8011, 16);
    tick(HALF);
    ncs = 1'b1;
    wait_drain();
    check("held_ncs_ignored", 64'(out_lo), 64'h000);
    send_frame(32'h8011, 16);
    check("out_lo_11", 64'(out_lo), 64'h011);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        nb = (($urandom_range(0, 1) == 0) ? 15 : 17);
        v = $urandom & ((32'd1 << nb) - 32'd1);
      end else begin
        nb = 16;
        v = {16'h0000, ($urandom_range(0, 3) != 0), 4'h0, 3'($urandom_range(0, 7)), 8'($urandom)};
      end
      send_frame(v, nb);
    end

    check("final_queue", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Write-only SPI mode-0 slave and register file that feeds the PWM peripheral's configuration inputs.
- Receives 16-bit frames from ui_in pins (SCLK, COPI, nCS), synchronises them into the clk domain, and decodes them.
- Commits valid writes to five 8-bit control registers: output enables, PWM enables and duty cycle.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2)
- MAX_ADDR, 7'h04, highest writable register address

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sclk  input  1  SPI clock pin (async)
- copi  input  1  SPI data pin (async)
- ncs  input  1  SPI chip select pin, active-low (async)
- en_reg_out_7_0  output  8  addr 0x00, output enable bits 7:0
- en_reg_out_15_8  output  8  addr 0x01, output enable bits 15:8
- en_reg_pwm_7_0  output  8  addr 0x02, PWM mode enable bits 7:0
- en_reg_pwm_15_8  output  8  addr 0x03, PWM mode enable bits 15:8
- pwm_duty_cycle  output  8  addr 0x04, duty cycle (0x00=0%, 0xFF=100%)
- wr_strobe  output  1  one-cycle pulse in the commit cycle of an accepted write
- frame_err  output  1  one-cycle pulse when a frame is discarded for wrong bit count

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on rst.
  - All five registers reset to 0x00; wr_strobe=0; frame_err=0.
  - Synchroniser flops reset to: ncs=1, sclk=0, copi=0.
  - Bit counter reset to 0; state reset to IDLE.
- Input synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops, then one history flop for edge detection.
  - sclk_rise = synced 1 and history 0.
  - ncs_fall and ncs_rise are derived the same way.
  - Constraint: f_clk >= 4 x f_sclk. Faster SCLK is out of spec and the behaviour is undefined.
- Frame format (MSB first, 16 bits):
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
  - COPI is sampled on the synced SCLK rising edge.
- State machine:
  - IDLE: on ncs_fall -> SHIFT; clear shift register and bit counter.
    - A frame with ncs already low out of reset is never accepted; nCS must first go high.
  - SHIFT:
    - Each sclk_rise shifts copi into the LSB; counter increments, saturating at 17.
    - On ncs_rise -> COMMIT.
  - COMMIT (exactly one cycle), then -> IDLE.
    - count==16 and bit15=1 and addr<=MAX_ADDR: write data to the addressed register; pulse wr_strobe.
    - count==16 and bit15=0 (read): ignored; no strobe, no error.
    - count==16 and addr>MAX_ADDR: ignored; no strobe, no error.
    - count!=16 (short or long frame): discard; pulse frame_err.
- Latency:
  - Register updates on the clk edge ending COMMIT, which is SYNC_STAGES+2 clk cycles after the nCS pin rises.
  - wr_strobe is high in the same cycle the new value becomes visible.
- Simultaneous events:
  - sclk_rise in the same cycle as ncs_rise is not sampled.
  - ncs_fall during COMMIT is honoured: the next cycle enters SHIFT directly with a cleared counter.
- Reset mid-frame:
  - The partial frame is dropped; registers return to 0x00.
  - The block waits for a fresh ncs_fall.
- Registers hold their value indefinitely between writes; there is no auto-clear.

Decomposition:
- Shared package spi_reg_pkg holds:
  - address constants ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY
  - FRAME_BITS=16
  - the state enum (IDLE, SHIFT, COMMIT)
- One natural sub-module, sync_edge:
  - Parameterised SYNC_STAGES, with a reset value.
  - Outputs the synced level plus rise and fall pulses.
  - Instantiated three times: sclk, copi (level only), ncs.

Test Plan:
- Write frame 0x80F0 (write, addr 0, data 0xF0) at f_sclk=f_clk/8:
  - en_reg_out_7_0=0xF0 with a one-cycle wr_strobe, SYNC_STAGES+2 cycles after nCS rises.
  - All other registers stay 0x00.
- Back-to-back writes 0x8480 then 0x83AA:
  - pwm_duty_cycle=0x80 and en_reg_pwm_15_8=0xAA.
  - Two strobes; earlier registers unchanged.
- Read frame 0x0155 and write to addr 0x05 (0x8577):
  - No register changes; no wr_strobe; no frame_err.
- Short frame (15 bits) and long frame (17 bits) of 0x80FF:
  - Register 0 unchanged; one frame_err pulse per frame.
- Assert rst after 8 bits of 0x8233, then release and send a full 0x8233:
  - First attempt leaves all registers 0x00.
  - Second sets en_reg_pwm_7_0=0x33.
- Hold ncs low across reset release, then clock 16 bits of 0x8011:
  - Ignored: en_reg_out_7_0 stays 0x00.
  - A following properly framed 0x8011 succeeds.
